// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl -- frame sequencer for an oversampling UART receiver.
//
// Purpose:
//   Tracks the position inside a serial frame (start, 8 data bits, optional
//   parity, stop) by counting receiver clocks per bit. It produces the
//   enables for the external sampler, deserializer and checker stages. It
//   raises data_valid for one cycle when a frame completes without error.
//
// Ports:
//   CLK          receiver clock (Prescale x baud rate)
//   RST          asynchronous active-low reset
//   RX_IN        serial line, idle high
//   Prescale     oversampling ratio 8/16/32; any other value acts as 8
//   PAR_EN       1 = frame carries a parity bit
//   strt_glitch  start-bit checker reports a glitch (sampled at end of START)
//   par_err      parity checker error flag
//   stp_err      stop-bit checker error flag
//   edge_cnt     clock index inside the current bit
//   bit_cnt      bit index inside the frame (0 = start bit)
//   dat_samp_en  sampler enable, high throughout an active frame
//   strt_chk_en  start-bit checker enable
//   deser_en     one-cycle shift strobe at the end of each data bit
//   par_chk_en   parity checker enable
//   stp_chk_en   stop-bit checker enable
//   finish_s     last clock of the current bit
//   disable_err  one-cycle pulse when a new frame starts; clears old flags
//   data_valid   frame completed cleanly (single cycle)
//
// Build option:
//   UART_RX_BACK2BACK_EN -- when defined, a start bit that coincides with
//   the ERR_CHK cycle is accepted immediately instead of one cycle later.
// ---------------------------------------------------------------------------
module uart_rx_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       finish_s,
    output logic       disable_err,
    output logic       data_valid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_ERR_CHK = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] edge_q, edge_d;
    logic [3:0] bit_q, bit_d;
    logic [5:0] last_edge_q, last_edge_d;   // Prescale-1 latched for this frame
    logic       par_en_q, par_en_d;         // PAR_EN latched for this frame
    logic       dis_err_q, dis_err_d;

    logic       active;
    logic       finish;
    logic       start_det;

    // Map the ratio to the last edge index of a bit; unsupported ratios
    // fall back to x8.
    function automatic logic [5:0] last_edge_of(input logic [5:0] p);
        logic [5:0] r;
        case (p)
            6'd16:   r = 6'd15;
            6'd32:   r = 6'd31;
            default: r = 6'd7;
        endcase
        return r;
    endfunction

    assign active = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);
    assign finish = active && (edge_q == last_edge_q);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            edge_q      <= 6'd0;
            bit_q       <= 4'd0;
            last_edge_q <= 6'd7;
            par_en_q    <= 1'b0;
            dis_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            bit_q       <= bit_d;
            last_edge_q <= last_edge_d;
            par_en_q    <= par_en_d;
            dis_err_q   <= dis_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        edge_d      = edge_q;
        bit_d       = bit_q;
        last_edge_d = last_edge_q;
        par_en_d    = par_en_q;
        dis_err_d   = 1'b0;
        start_det   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!RX_IN) start_det = 1'b1;
            end
            S_START: begin
                if (finish) state_d = strt_glitch ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (finish && (bit_q == 4'd8)) state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (finish) state_d = S_STOP;
            end
            S_STOP: begin
                if (finish) state_d = S_ERR_CHK;
            end
            S_ERR_CHK: begin
                state_d = S_IDLE;
`ifdef UART_RX_BACK2BACK_EN
                if (!RX_IN) start_det = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (active) begin
            edge_d = finish ? 6'd0 : edge_q + 6'd1;
            bit_d  = finish ? bit_q + 4'd1 : bit_q;
        end

        // Counters rest at zero whenever the line is not being timed.
        if ((state_d == S_IDLE) || (state_d == S_ERR_CHK)) begin
            edge_d = 6'd0;
            bit_d  = 4'd0;
        end

        // The detection cycle is edge 0 of the start bit, so START opens at 1.
        // Frame configuration is captured here and held until the next start.
        if (start_det) begin
            state_d     = S_START;
            edge_d      = 6'd1;
            bit_d       = 4'd0;
            last_edge_d = last_edge_of(Prescale);
            par_en_d    = PAR_EN;
            dis_err_d   = 1'b1;
        end
    end

    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign dat_samp_en = active;
    assign strt_chk_en = (state_q == S_START);
    assign deser_en    = (state_q == S_DATA) && finish;
    assign par_chk_en  = (state_q == S_PARITY);
    assign stp_chk_en  = (state_q == S_STOP);
    assign finish_s    = finish;
    assign disable_err = dis_err_q;
    assign data_valid  = (state_q == S_ERR_CHK) && !stp_err && (!par_en_q || !par_err);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       finish_s;
    logic       disable_err;
    logic       data_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_rx_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .deser_en    (deser_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .finish_s    (finish_s),
        .disable_err (disable_err),
        .data_valid  (data_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Serial level for cycle k of a frame (k=0 is the start detection cycle).
    function automatic logic frame_bit(input int k, input int p, input logic [7:0] d);
        int idx;
        idx = k / p;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [25:0] all_outs();
        return {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
                stp_chk_en, finish_s, disable_err, data_valid, 8'h00};
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        RST = 1'b0; RX_IN = 1'b0; Prescale = 6'd8; PAR_EN = 1'b0;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (all_outs() !== 26'd0) begin
            n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs());
        end
        #1 RX_IN = 1'b1; RST = 1'b1;
        repeat (3) next_cycle();
        @(negedge CLK);
        n_cmp++;
        if (all_outs() !== 26'd0) begin
            n_fail++; $display("FAIL reset_idle: got %h want 0", all_outs());
        end
        next_cycle();
        RX_IN = 1'b0;
        next_cycle();
        @(negedge CLK);
        n_cmp++;
        if ({edge_cnt, bit_cnt, strt_chk_en, disable_err} !== {6'd1, 4'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL first_start: edge=%0d bit=%0d strt=%b dis=%b want 1 0 1 1",
                     edge_cnt, bit_cnt, strt_chk_en, disable_err);
        end
    endtask

    task automatic test_basic_frame();
        int n_fin;
        n_fin = 0;
        do_reset();
        Prescale = 6'd8; PAR_EN = 1'b0;
        for (int k = 0; k <= 84; k++) begin
            RX_IN = frame_bit(k, 8, 8'hA5);
            @(negedge CLK);
            if (finish_s) n_fin++;
            n_cmp++;
            if (finish_s !== (k >= 7 && k <= 79 && (k % 8) == 7)) begin
                n_fail++; $display("FAIL basic_finish k=%0d: got %b", k, finish_s);
            end
            n_cmp++;
            if (data_valid !== (k == 80)) begin
                n_fail++; $display("FAIL basic_valid k=%0d: got %b", k, data_valid);
            end
            n_cmp++;
            if (disable_err !== (k == 1)) begin
                n_fail++; $display("FAIL basic_diserr k=%0d: got %b", k, disable_err);
            end
            if (k >= 1 && k <= 79) begin
                n_cmp++;
                if (edge_cnt !== 6'(k % 8) || bit_cnt !== 4'(k / 8)) begin
                    n_fail++;
                    $display("FAIL basic_cnt k=%0d: edge=%0d bit=%0d want %0d %0d",
                             k, edge_cnt, bit_cnt, k % 8, k / 8);
                end
            end
            n_cmp++;
            if (stp_chk_en !== (k >= 72 && k <= 79) || par_chk_en !== 1'b0) begin
                n_fail++; $display("FAIL basic_stp k=%0d: stp=%b par=%b", k, stp_chk_en, par_chk_en);
            end
            next_cycle();
        end
        n_cmp++;
        if (n_fin != 10) begin
            n_fail++; $display("FAIL basic_fin_count: got %0d want 10", n_fin);
        end
    endtask

    task automatic test_parity_stop_err();
        do_reset();
        Prescale = 6'd16; PAR_EN = 1'b1; stp_err = 1'b1;
        for (int k = 0; k <= 180; k++) begin
            RX_IN = frame_bit(k, 16, 8'h3C);
            @(negedge CLK);
            n_cmp++;
            if (par_chk_en !== (k >= 144 && k <= 159)) begin
                n_fail++; $display("FAIL par_window k=%0d: got %b", k, par_chk_en);
            end
            n_cmp++;
            if (data_valid !== 1'b0) begin
                n_fail++; $display("FAIL stperr_valid k=%0d: got %b want 0", k, data_valid);
            end
            n_cmp++;
            if (stp_chk_en !== (k >= 160 && k <= 175)) begin
                n_fail++; $display("FAIL par_stop k=%0d: got %b", k, stp_chk_en);
            end
            next_cycle();
        end
        stp_err = 1'b0;
    endtask

    task automatic test_par_err();
        // PAR_EN=1 with par_err: no data_valid (ERR_CHK at 88).
        do_reset();
        Prescale = 6'd8; PAR_EN = 1'b1; par_err = 1'b1;
        for (int k = 0; k <= 90; k++) begin
            RX_IN = frame_bit(k, 8, 8'h81);
            @(negedge CLK);
            if (k == 88) begin
                n_cmp++;
                if (data_valid !== 1'b0 || dat_samp_en !== 1'b0) begin
                    n_fail++; $display("FAIL parerr_valid: got dv=%b samp=%b want 0 0", data_valid, dat_samp_en);
                end
            end
            if (k == 87) begin
                n_cmp++;
                if (stp_chk_en !== 1'b1 || finish_s !== 1'b1) begin
                    n_fail++; $display("FAIL parerr_stop: stp=%b fin=%b want 1 1", stp_chk_en, finish_s);
                end
            end
            next_cycle();
        end
        // PAR_EN=0: par_err is ignored.
        do_reset();
        Prescale = 6'd8; PAR_EN = 1'b0; par_err = 1'b1;
        for (int k = 0; k <= 82; k++) begin
            RX_IN = frame_bit(k, 8, 8'h81);
            @(negedge CLK);
            n_cmp++;
            if (data_valid !== (k == 80)) begin
                n_fail++; $display("FAIL noparen_valid k=%0d: got %b", k, data_valid);
            end
            next_cycle();
        end
        // Parity enabled, no errors: valid at 88.
        do_reset();
        Prescale = 6'd8; PAR_EN = 1'b1; par_err = 1'b0;
        for (int k = 0; k <= 90; k++) begin
            RX_IN = frame_bit(k, 8, 8'h81);
            @(negedge CLK);
            n_cmp++;
            if (data_valid !== (k == 88)) begin
                n_fail++; $display("FAIL parok_valid k=%0d: got %b", k, data_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_glitch();
        do_reset();
        Prescale = 6'd8; PAR_EN = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            RX_IN = (k == 0) ? 1'b0 : 1'b1;
            strt_glitch = (k == 7);
            @(negedge CLK);
            n_cmp++;
            if (deser_en !== 1'b0) begin
                n_fail++; $display("FAIL glitch_deser k=%0d: got %b want 0", k, deser_en);
            end
            n_cmp++;
            if (dat_samp_en !== (k >= 1 && k <= 7)) begin
                n_fail++; $display("FAIL glitch_samp k=%0d: got %b", k, dat_samp_en);
            end
            if (k == 8) begin
                n_cmp++;
                if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
                    n_fail++; $display("FAIL glitch_idle: edge=%0d bit=%0d want 0 0", edge_cnt, bit_cnt);
                end
            end
            next_cycle();
        end
        strt_glitch = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        Prescale = 6'd8; PAR_EN = 1'b0;
        for (int k = 0; k < 30; k++) begin
            RX_IN = frame_bit(k, 8, 8'hFF);
            next_cycle();
        end
        RST = 1'b0;
        #1;
        n_cmp++;
        if (all_outs() !== 26'd0) begin
            n_fail++; $display("FAIL midreset_outs: got %h want 0", all_outs());
        end
        next_cycle();
        RST = 1'b1; RX_IN = 1'b1;
        for (int k = 0; k < 90; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (dat_samp_en !== 1'b0 || data_valid !== 1'b0) begin
                n_fail++; $display("FAIL midreset_idle k=%0d: samp=%b dv=%b want 0 0", k, dat_samp_en, data_valid);
            end
            next_cycle();
        end
        RX_IN = 1'b0;
        next_cycle();
        @(negedge CLK);
        n_cmp++;
        if (strt_chk_en !== 1'b1 || edge_cnt !== 6'd1) begin
            n_fail++; $display("FAIL midreset_restart: strt=%b edge=%0d want 1 1", strt_chk_en, edge_cnt);
        end
        next_cycle();
    endtask

    task automatic test_prescale32();
        int n_des;
        n_des = 0;
        do_reset();
        Prescale = 6'd32; PAR_EN = 1'b0;
        for (int k = 0; k <= 322; k++) begin
            RX_IN = frame_bit(k, 32, 8'h5A);
            @(negedge CLK);
            if (deser_en) n_des++;
            n_cmp++;
            if (deser_en !== (k >= 63 && k <= 287 && (k % 32) == 31)) begin
                n_fail++; $display("FAIL p32_deser k=%0d: got %b", k, deser_en);
            end
            if (deser_en && bit_cnt !== 4'(k / 32)) begin
                n_cmp++; n_fail++;
                $display("FAIL p32_bitcnt k=%0d: got %0d want %0d", k, bit_cnt, k / 32);
            end
            n_cmp++;
            if (data_valid !== (k == 320)) begin
                n_fail++; $display("FAIL p32_valid k=%0d: got %b", k, data_valid);
            end
            next_cycle();
        end
        n_cmp++;
        if (n_des != 8) begin
            n_fail++; $display("FAIL p32_deser_count: got %0d want 8", n_des);
        end
    endtask

    task automatic test_bad_prescale_and_midframe();
        // Unsupported ratio acts as x8.
        do_reset();
        Prescale = 6'd5; PAR_EN = 1'b0;
        for (int k = 0; k <= 82; k++) begin
            RX_IN = frame_bit(k, 8, 8'h11);
            @(negedge CLK);
            n_cmp++;
            if (finish_s !== (k >= 7 && k <= 79 && (k % 8) == 7) || data_valid !== (k == 80)) begin
                n_fail++; $display("FAIL badpresc k=%0d: fin=%b dv=%b", k, finish_s, data_valid);
            end
            next_cycle();
        end
        // Configuration changes mid-frame are ignored.
        do_reset();
        Prescale = 6'd8; PAR_EN = 1'b0;
        for (int k = 0; k <= 82; k++) begin
            RX_IN = frame_bit(k, 8, 8'h22);
            if (k == 3) begin
                Prescale = 6'd16; PAR_EN = 1'b1;
            end
            @(negedge CLK);
            n_cmp++;
            if (par_chk_en !== 1'b0 || data_valid !== (k == 80)) begin
                n_fail++; $display("FAIL midcfg k=%0d: par=%b dv=%b", k, par_chk_en, data_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        Prescale = 6'd8; PAR_EN = 1'b0;
        for (int k = 0; k <= 84; k++) begin
            RX_IN = (k >= 80) ? 1'b0 : frame_bit(k, 8, 8'hA5);
            @(negedge CLK);
            if (k == 80) begin
                n_cmp++;
                if (data_valid !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_valid: got %b want 1", data_valid);
                end
            end
`ifdef UART_RX_BACK2BACK_EN
            if (k == 81) begin
                n_cmp++;
                if (strt_chk_en !== 1'b1 || edge_cnt !== 6'd1 || disable_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_start81: strt=%b edge=%0d dis=%b want 1 1 1", strt_chk_en, edge_cnt, disable_err);
                end
            end
`else
            if (k == 81) begin
                n_cmp++;
                if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin
                    n_fail++; $display("FAIL b2b_idle81: samp=%b edge=%0d want 0 0", dat_samp_en, edge_cnt);
                end
            end
            if (k == 82) begin
                n_cmp++;
                if (strt_chk_en !== 1'b1 || edge_cnt !== 6'd1 || disable_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_start82: strt=%b edge=%0d dis=%b want 1 1 1", strt_chk_en, edge_cnt, disable_err);
                end
            end
`endif
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity_stop_err();
        test_par_err();
        test_glitch();
        test_reset_mid_frame();
        test_prescale32();
        test_bad_prescale_and_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL provide ports: CLK  in  1  receiver clock (prescale x baud).
REQ-002 SHALL provide: RST  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: RX_IN  in  1  serial line, idle high.
REQ-004 SHALL provide: Prescale  in  6  oversampling ratio; 8, 16 or 32.
REQ-005 SHALL provide: PAR_EN  in  1  1 = parity bit present.
REQ-006 SHALL provide: strt_glitch, par_err, stp_err  in  1 each  error flags from checker stages.
REQ-007 SHALL provide: edge_cnt  out  6  cycle index within current bit; bit_cnt  out  4  bit index in frame (0 = start).
REQ-008 SHALL provide: dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, finish_s, disable_err, data_valid  out  1 each.

Function
REQ-009 SHALL implement states IDLE, START, DATA, PARITY, STOP, ERR_CHK.
REQ-010 IDLE: edge_cnt=0, bit_cnt=0; RX_IN=0 sampled -> START next cycle, detection cycle counts as edge 0 (START entered with edge_cnt=1).
REQ-011 In START/DATA/PARITY/STOP edge_cnt SHALL increment each cycle, wrap prescale-1 -> 0, and bit_cnt SHALL increment on each wrap.
REQ-012 finish_s SHALL be high exactly when edge_cnt == prescale-1 in START/DATA/PARITY/STOP.
REQ-013 START at finish_s: strt_glitch=1 -> IDLE; else -> DATA.
REQ-014 DATA at finish_s with bit_cnt==8 -> PARITY if PAR_EN else STOP.
REQ-015 PARITY at finish_s -> STOP; STOP at finish_s -> ERR_CHK; ERR_CHK lasts one cycle -> IDLE.
REQ-016 Enables (combinational from state): strt_chk_en in START, deser_en = finish_s in DATA, par_chk_en in PARITY, stp_chk_en in STOP, dat_samp_en in START/DATA/PARITY/STOP.
REQ-017 disable_err SHALL pulse for one cycle on the IDLE->START transition cycle, clearing previous-frame error flags.
REQ-018 data_valid SHALL be high for the single ERR_CHK cycle iff par_err=0 (or PAR_EN=0) and stp_err=0.
REQ-019 Prescale values other than 8/16/32 SHALL behave as 8.
REQ-020 PAR_EN and Prescale SHALL be sampled only in IDLE; changes mid-frame have no effect until next frame.
REQ-021 RX_IN activity outside IDLE (and ERR_CHK per REQ-025) SHALL NOT affect state flow.

Reset
REQ-022 RST low SHALL asynchronously force state=IDLE, edge_cnt=0, bit_cnt=0, all outputs 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no data_valid; after release, the controller waits in IDLE for the next RX_IN=0.

Configuration
REQ-024 Macro UART_RX_BACK2BACK_EN SHALL control back-to-back frame reception.
REQ-025 Defined: ERR_CHK with RX_IN=0 SHALL go directly to START (edge_cnt=1, disable_err pulsed), data_valid still asserted per REQ-018.
REQ-026 Undefined: ERR_CHK SHALL always go to IDLE; a start bit coinciding with ERR_CHK is detected one cycle later.

Verification
REQ-027 Prescale=8, PAR_EN=0, frame 0xA5 with RX_IN low at cycle t -> finish_s at t+7,t+15,...,t+79; data_valid=1 at t+80 only.
REQ-028 Prescale=16, PAR_EN=1, stp_err=1 at ERR_CHK -> data_valid stays 0; par_chk_en high for cycles t+144..t+159.
REQ-029 Prescale=8, strt_glitch=1 at t+7 -> IDLE at t+8, no DATA state, deser_en never pulses.
REQ-030 RST low at t+30 mid-DATA -> all outputs 0 immediately; next RX_IN low restarts at START, edge_cnt=1.
REQ-031 Prescale=32, PAR_EN=0 -> exactly 8 deser_en pulses at t+63, t+95, ..., t+287; bit_cnt 1..8.
REQ-032 Two frames, second start at t+80: with UART_RX_BACK2BACK_EN START at t+81; without, START at t+82.
